// File: rtl/stack_ctrl_fsm.sv
// Multicycle control unit for the stack CPU: decodes the 16-opcode ISA into datapath strobes,
// stalls on the memory ready handshake, and keeps halt/fault status and a retired-instruction count.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// INIT      | reset PC and both stack pointers
// FETCH     | read instruction and top of stack (memory)
// DECODE    | dispatch on opcode, catch halt marker and illegal opcodes
// POP_A     | pop first operand
// READ_B    | read second operand (memory)
// EXEC      | ALU operation into result register
// WB        | write result back to stack (memory)
// BR_DO     | conditional branch on zero flag
// POP_WR    | pop write-back (memory)
// SHIFT     | shifter operation into result register
// JP_PUSH   | call: pop target, push return stack
// JP_WR     | call: store return address (memory)
// JR_RD     | return: read return address (memory)
// JR_POP    | return: drop return stack entry
// JUMP      | load PC from target
// JPOP      | jump to popped target
// PUSH_RD   | push: read source (memory)
// PUSH_WR   | push: write stack (memory)
// PUSHI_INC | push immediate: grow stack
// PUSHI_WR  | push immediate: write stack (memory)
// HALT      | stopped until reset (halt instruction, watchdog or bad opcode)

module stack_ctrl_fsm #(
    parameter int OP_W       = 4,
    parameter int IMM_W      = 12,
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op,
    input  logic [IMM_W-1:0] imm,
    input  logic             is_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_add,
    output logic             pc_source,
    output logic             sp_reset,
    output logic             msp_write,
    output logic             msp_pop,
    output logic             rsp_write,
    output logic             rsp_pop,
    output logic             ir_write,
    output logic             vala_write,
    output logic             valb_write,
    output logic             res_write,
    output logic             res_source,
    output logic [2:0]       alu_op,
    output logic             shift_dir,
    output logic             shift_mode,
    output logic             mem_rd1,
    output logic             mem_rd2,
    output logic             mem_wr2,
    output logic [1:0]       mem_dst1,
    output logic [1:0]       mem_dst2,
    output logic [1:0]       mem_data,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [4:0]       state
);

    localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(WAIT_LIMIT - 1);

    typedef enum logic [4:0] {
        INIT      = 5'd0,  FETCH     = 5'd1,  DECODE    = 5'd2,  POP_A     = 5'd3,
        READ_B    = 5'd4,  EXEC      = 5'd5,  WB        = 5'd6,  BR_DO     = 5'd7,
        POP_WR    = 5'd8,  SHIFT     = 5'd9,  JP_PUSH   = 5'd10, JP_WR     = 5'd11,
        JR_RD     = 5'd12, JR_POP    = 5'd13, JUMP      = 5'd14, JPOP      = 5'd15,
        PUSH_RD   = 5'd16, PUSH_WR   = 5'd17, PUSHI_INC = 5'd18, PUSHI_WR  = 5'd19,
        HALT      = 5'd20
    } state_t;

    state_t          cur_state, next_state;
    logic [WC_W-1:0] wait_cnt;
    logic [OP_W-1:0] op_hi;
    logic [3:0]      opc;
    logic            mem_state, to_fault, retire;

    assign opc    = op[3:0];
    assign op_hi  = op >> 4;
    assign state  = cur_state;
    assign halted = (cur_state == HALT);

    always_comb begin
        next_state = cur_state;
        mem_state  = 1'b0;
        to_fault   = 1'b0;
        pc_write   = 1'b0;  pc_add     = 1'b0;  pc_source  = 1'b0;  sp_reset   = 1'b0;
        msp_write  = 1'b0;  msp_pop    = 1'b0;  rsp_write  = 1'b0;  rsp_pop    = 1'b0;
        ir_write   = 1'b0;  vala_write = 1'b0;  valb_write = 1'b0;  res_write  = 1'b0;
        res_source = 1'b0;  alu_op     = 3'd0;  shift_dir  = 1'b0;  shift_mode = 1'b0;
        mem_rd1    = 1'b0;  mem_rd2    = 1'b0;  mem_wr2    = 1'b0;
        mem_dst1   = 2'd0;  mem_dst2   = 2'd0;  mem_data   = 2'd0;
        // Strobes are forced low for as long as reset is held, including the INIT ones.
        if (rst) begin
            case (cur_state)
                INIT: begin
                    pc_write = 1'b1;  msp_write = 1'b1;  rsp_write = 1'b1;  sp_reset = 1'b1;
                    next_state = FETCH;
                end
                FETCH: begin
                    mem_state = 1'b1;
                    ir_write = 1'b1;  vala_write = 1'b1;  mem_rd1 = 1'b1;  mem_rd2 = 1'b1;
                    pc_write = mem_ready;
                    if (mem_ready) next_state = DECODE;
                end
                DECODE: begin
                    if (op_hi != '0) begin
                        next_state = HALT;
                        to_fault   = 1'b1;
                    end else begin
                        case (opc)
                            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hD: next_state = POP_A;
                            4'hC:              next_state = (&imm) ? HALT : POP_A;
                            4'h8, 4'h9, 4'hA:  next_state = SHIFT;
                            4'h6:              next_state = JP_PUSH;
                            4'h7:              next_state = JR_RD;
                            4'h5:              next_state = JPOP;
                            4'hE:              next_state = PUSH_RD;
                            default:           next_state = PUSHI_INC;
                        endcase
                    end
                end
                POP_A: begin
                    msp_write = 1'b1;  msp_pop = 1'b1;
                    next_state = READ_B;
                end
                READ_B: begin
                    mem_state = 1'b1;
                    valb_write = mem_ready;  mem_rd1 = 1'b1;  mem_dst1 = 2'd1;
                    if (mem_ready) begin
                        if (opc <= 4'h4)                    next_state = EXEC;
                        else if (opc == 4'hB || opc == 4'hC) next_state = BR_DO;
                        else                                 next_state = POP_WR;
                    end
                end
                EXEC: begin
                    res_write = 1'b1;
                    // opcode order: add, sub, and, or, slt
                    case (opc)
                        4'h0:    alu_op = 3'd2;
                        4'h1:    alu_op = 3'd4;
                        4'h2:    alu_op = 3'd0;
                        4'h3:    alu_op = 3'd1;
                        4'h4:    alu_op = 3'd3;
                        default: alu_op = 3'd0;
                    endcase
                    next_state = WB;
                end
                WB: begin
                    mem_state = 1'b1;
                    mem_rd2 = 1'b1;  mem_wr2 = 1'b1;  mem_dst2 = 2'd0;  mem_data = 2'd1;
                    if (mem_ready) next_state = FETCH;
                end
                BR_DO: begin
                    msp_write = 1'b1;  msp_pop = 1'b1;  alu_op = 3'd4;  pc_add = 1'b1;
                    pc_write = (opc == 4'hC) ? is_zero : !is_zero;
                    next_state = FETCH;
                end
                POP_WR: begin
                    mem_state = 1'b1;
                    mem_wr2 = 1'b1;  mem_dst2 = 2'd2;  mem_data = 2'd3;
                    msp_write = mem_ready;  msp_pop = mem_ready;
                    if (mem_ready) next_state = FETCH;
                end
                SHIFT: begin
                    res_write = 1'b1;  res_source = 1'b1;
                    shift_dir  = (opc == 4'h9) || (opc == 4'hA);
                    shift_mode = (opc == 4'hA);
                    next_state = WB;
                end
                JP_PUSH: begin
                    msp_write = 1'b1;  msp_pop = 1'b1;  rsp_write = 1'b1;  rsp_pop = 1'b1;
                    next_state = JP_WR;
                end
                JP_WR: begin
                    mem_state = 1'b1;
                    mem_wr2 = 1'b1;  mem_dst2 = 2'd1;  mem_data = 2'd0;
                    if (mem_ready) next_state = JUMP;
                end
                JR_RD: begin
                    mem_state = 1'b1;
                    vala_write = mem_ready;  mem_rd2 = 1'b1;  mem_dst2 = 2'd1;
                    if (mem_ready) next_state = JR_POP;
                end
                JR_POP: begin
                    rsp_write = 1'b1;
                    next_state = JUMP;
                end
                JUMP: begin
                    pc_write = 1'b1;  pc_source = 1'b1;
                    next_state = FETCH;
                end
                JPOP: begin
                    pc_write = 1'b1;  pc_source = 1'b1;  msp_write = 1'b1;  msp_pop = 1'b1;
                    next_state = FETCH;
                end
                PUSH_RD: begin
                    mem_state = 1'b1;
                    valb_write = mem_ready;  mem_rd1 = 1'b1;  mem_dst1 = 2'd2;
                    if (mem_ready) next_state = PUSH_WR;
                end
                PUSH_WR: begin
                    mem_state = 1'b1;
                    mem_wr2 = 1'b1;  mem_dst2 = 2'd0;  mem_data = 2'd3;
                    if (mem_ready) next_state = FETCH;
                end
                PUSHI_INC: begin
                    msp_write = 1'b1;
                    next_state = PUSHI_WR;
                end
                PUSHI_WR: begin
                    mem_state = 1'b1;
                    mem_wr2 = 1'b1;  mem_dst2 = 2'd0;  mem_data = 2'd2;
                    if (mem_ready) next_state = FETCH;
                end
                default: next_state = HALT;
            endcase
            if (mem_state && !mem_ready && wait_cnt == '0) begin
                next_state = HALT;
                to_fault   = 1'b1;
            end
        end
    end

    assign retire = (next_state == FETCH) && (cur_state != FETCH) && (cur_state != INIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= INIT;
            wait_cnt  <= WAIT_LOAD;
            fault     <= 1'b0;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            // Watchdog down-counter reloads on every state change.
            if (next_state != cur_state)
                wait_cnt <= WAIT_LOAD;
            else if (!mem_ready && wait_cnt != '0)
                wait_cnt <= wait_cnt - WC_W'(1);
            if (to_fault)
                fault <= 1'b1;
            if (retire && retired != '1)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
